// File: rtl/easyaxi_ost_sched_if.sv
// easyaxi_ost_sched_if: request, completion and response signals of the outstanding-slot scheduler.
interface easyaxi_ost_sched_if #(
    parameter int OST_DEPTH = 16,
    parameter int ID_WIDTH  = 4
);
    localparam int PW = $clog2(OST_DEPTH);
    logic                 alloc_valid;
    logic                 alloc_ready;
    logic [ID_WIDTH-1:0]  alloc_id;
    logic [PW-1:0]        alloc_ptr;
    logic                 done_valid;
    logic [PW-1:0]        done_ptr;
    logic [OST_DEPTH-1:0] order_bits;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [PW-1:0]        resp_ptr;
    logic [ID_WIDTH-1:0]  resp_id;
    logic [PW:0]          ost_cnt;
    logic                 err_done;
    modport slave (
        input  alloc_valid, alloc_id, done_valid, done_ptr, order_bits, resp_ready,
        output alloc_ready, alloc_ptr, resp_valid, resp_ptr, resp_id, ost_cnt, err_done
    );
    modport master (
        output alloc_valid, alloc_id, done_valid, done_ptr, order_bits, resp_ready,
        input  alloc_ready, alloc_ptr, resp_valid, resp_ptr, resp_id, ost_cnt, err_done
    );
endinterface

// File: rtl/easyaxi_ost_sched.sv
// easyaxi_ost_sched: allocates outstanding slots, tracks completion and returns
// in-order-eligible responses one at a time with round-robin selection.
module easyaxi_ost_sched #(
    parameter int OST_DEPTH = 16,
    parameter int ID_WIDTH  = 4
) (
    input logic                clk,
    input logic                rst,
    easyaxi_ost_sched_if.slave ost_if
);
    localparam int PW = $clog2(OST_DEPTH);
    typedef enum logic {IDLE, BUSY} state_e;
    state_e               state_q, state_d;
    logic [OST_DEPTH-1:0] vld_q, vld_d, done_q, done_d, pend_q, pend_d, elig, cand;
    logic [ID_WIDTH-1:0]  id_q [OST_DEPTH];
    logic [ID_WIDTH-1:0]  resp_id_q, resp_id_d;
    logic [PW-1:0]        resp_ptr_q, resp_ptr_d, rr_base_q, rr_base_d, free_ptr, gnt_ptr, idx;
    logic [PW:0]          cnt_q, cnt_d;
    logic                 err_q, err_d, alloc_fire, free, gnt_found, gnt;

    assign ost_if.alloc_ready = ~&vld_q;
    assign ost_if.alloc_ptr   = free_ptr;
    assign ost_if.resp_valid  = state_q == BUSY;
    assign ost_if.resp_ptr    = resp_ptr_q;
    assign ost_if.resp_id     = resp_id_q;
    assign ost_if.ost_cnt     = cnt_q;
    assign ost_if.err_done    = err_q;
    assign alloc_fire = ost_if.alloc_valid & ~&vld_q;
    assign free       = (state_q == BUSY) & ost_if.resp_ready;
    assign elig       = vld_q & done_q & ~pend_q & ost_if.order_bits;
    assign gnt        = gnt_found & ((state_q == IDLE) | ost_if.resp_ready);

    always_comb begin
        free_ptr = '0;
        for (int i = OST_DEPTH - 1; i >= 0; i--)
            if (!vld_q[i]) free_ptr = PW'(i);
    end

    // Round-robin search over eligible slots starting at rr_base; the presented slot never competes.
    always_comb begin
        cand = elig;
        if (state_q == BUSY) cand[resp_ptr_q] = 1'b0;
        gnt_found = 1'b0;
        gnt_ptr   = '0;
        idx       = '0;
        for (int i = 0; i < OST_DEPTH; i++) begin
            idx = rr_base_q + PW'(i);
            if (!gnt_found && cand[idx]) begin
                gnt_found = 1'b1;
                gnt_ptr   = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        vld_d      = vld_q;
        done_d     = done_q;
        pend_d     = pend_q;
        resp_ptr_d = resp_ptr_q;
        resp_id_d  = resp_id_q;
        rr_base_d  = rr_base_q;
        cnt_d      = cnt_q + (PW+1)'(alloc_fire) - (PW+1)'(free);
        err_d      = err_q | (ost_if.done_valid & ~vld_q[ost_if.done_ptr]);
        if (ost_if.done_valid && vld_q[ost_if.done_ptr]) done_d[ost_if.done_ptr] = 1'b1;
        if (free) begin
            vld_d[resp_ptr_q]  = 1'b0;
            done_d[resp_ptr_q] = 1'b0;
            pend_d[resp_ptr_q] = 1'b0;
            state_d            = IDLE;
        end
        if (alloc_fire) begin
            vld_d[free_ptr]  = 1'b1;
            done_d[free_ptr] = 1'b0;
            pend_d[free_ptr] = 1'b0;
        end
        if (gnt) begin
            pend_d[gnt_ptr] = 1'b1;
            resp_ptr_d      = gnt_ptr;
            resp_id_d       = id_q[gnt_ptr];
            rr_base_d       = gnt_ptr + PW'(1);
            state_d         = BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            vld_q      <= '0;
            done_q     <= '0;
            pend_q     <= '0;
            resp_ptr_q <= '0;
            resp_id_q  <= '0;
            rr_base_q  <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            vld_q      <= vld_d;
            done_q     <= done_d;
            pend_q     <= pend_d;
            resp_ptr_q <= resp_ptr_d;
            resp_id_q  <= resp_id_d;
            rr_base_q  <= rr_base_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk)
        if (alloc_fire) id_q[free_ptr] <= ost_if.alloc_id;
endmodule

// File: tb/tb_easyaxi_ost_sched.sv
// tb_easyaxi_ost_sched: directed test-plan scenarios plus randomized traffic,
// every cycle compared against a slot-level behavioural model.
module tb_easyaxi_ost_sched;
    localparam int D  = 16;
    localparam int IW = 4;
    localparam int PW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    easyaxi_ost_sched_if #(.OST_DEPTH(D), .ID_WIDTH(IW)) bus ();
    easyaxi_ost_sched #(.OST_DEPTH(D), .ID_WIDTH(IW)) dut (.clk(clk), .rst(rst), .ost_if(bus));

    int checks = 0;
    int errors = 0;

    bit m_vld [D];
    bit m_done[D];
    int m_id  [D];
    int m_seq [D];
    int m_pend, m_rr, m_rptr, m_rid, m_next_seq;
    bit m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < D; k++) begin
            m_vld[k] = 0; m_done[k] = 0; m_id[k] = 0; m_seq[k] = 0;
        end
        m_pend = -1; m_rr = 0; m_rptr = 0; m_rid = 0; m_err = 0; m_next_seq = 0;
    endtask

    function automatic int m_free_slot();
        for (int k = 0; k < D; k++) if (!m_vld[k]) return k;
        return -1;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int k = 0; k < D; k++) c += int'(m_vld[k]);
        return c;
    endfunction

    // Head-of-queue per ID: the oldest allocated slot carrying that ID.
    function automatic logic [D-1:0] m_heads();
        logic [D-1:0] h = '0;
        for (int k = 0; k < D; k++) begin
            bit head = m_vld[k];
            for (int j = 0; j < D; j++)
                if (j != k && m_vld[j] && m_id[j] == m_id[k] && m_seq[j] < m_seq[k]) head = 0;
            h[k] = head;
        end
        return h;
    endfunction

    task automatic model_step(input bit av, input int aid, input bit dv, input int dptr,
                              input logic [D-1:0] ob, input bit rr);
        int  fp    = m_free_slot();
        int  g     = -1;
        bit  freed = (m_pend >= 0) && rr;
        if (m_pend < 0 || freed)
            for (int j = 0; j < D; j++) begin
                int k = (m_rr + j) % D;
                if (g < 0 && m_vld[k] && m_done[k] && k != m_pend && ob[k]) g = k;
            end
        if (dv) begin
            if (m_vld[dptr]) m_done[dptr] = 1;
            else m_err = 1;
        end
        if (freed) begin
            m_vld[m_pend] = 0; m_done[m_pend] = 0;
        end
        if (av && fp >= 0) begin
            m_vld[fp] = 1; m_done[fp] = 0; m_id[fp] = aid; m_seq[fp] = m_next_seq++;
        end
        if (g >= 0) begin
            m_pend = g; m_rptr = g; m_rid = m_id[g]; m_rr = (g + 1) % D;
        end else if (freed) m_pend = -1;
    endtask

    task automatic check_outputs();
        int fp = m_free_slot();
        chk("alloc_ready", bus.alloc_ready, fp >= 0);
        chk("alloc_ptr",   bus.alloc_ptr, fp >= 0 ? fp : 0);
        chk("ost_cnt",     bus.ost_cnt, m_count());
        chk("resp_valid",  bus.resp_valid, m_pend >= 0);
        chk("resp_ptr",    bus.resp_ptr, m_rptr);
        chk("resp_id",     bus.resp_id, m_rid);
        chk("err_done",    bus.err_done, m_err);
    endtask

    task automatic cycle(input bit av, input int aid, input bit dv, input int dptr,
                         input logic [D-1:0] ob, input bit rr);
        @(negedge clk);
        rst = 1'b0;
        bus.alloc_valid = av;  bus.alloc_id = IW'(aid);
        bus.done_valid  = dv;  bus.done_ptr = PW'(dptr);
        bus.order_bits  = ob;  bus.resp_ready = rr;
        #1 check_outputs();
        @(posedge clk);
        model_step(av, aid, dv, dptr, ob, rr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.alloc_valid = 0; bus.alloc_id = '0; bus.done_valid = 0; bus.done_ptr = '0;
        bus.order_bits = '0; bus.resp_ready = 0;
        @(posedge clk);
        model_reset();
        #1;
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_ptr",   bus.resp_ptr, 0);
        chk("rst_resp_id",    bus.resp_id, 0);
        chk("rst_ost_cnt",    bus.ost_cnt, 0);
        chk("rst_err_done",   bus.err_done, 0);
        chk("rst_alloc_ready", bus.alloc_ready, 1);
        chk("rst_alloc_ptr",  bus.alloc_ptr, 0);
    endtask

    initial begin
        model_reset();
        // allocation order and ID-order enforcement
        do_reset();
        for (int i = 0; i < 3; i++) begin
            chk("alloc_seq_ptr", bus.alloc_ptr, i);
            cycle(1, (i == 2) ? 2 : 5, 0, 0, '0, 0);
            #1;
        end
        chk("alloc_cnt3", bus.ost_cnt, 3);
        cycle(0, 0, 1, 1, 16'h0005, 1);
        cycle(0, 0, 0, 0, 16'h0005, 1); #1 chk("order_blocked", bus.resp_valid, 0);
        cycle(0, 0, 1, 0, 16'h0005, 0);
        cycle(0, 0, 0, 0, 16'h0005, 0); #1;
        chk("head_valid", bus.resp_valid, 1);
        chk("head_ptr", bus.resp_ptr, 0);
        chk("head_id", bus.resp_id, 5);
        cycle(0, 0, 0, 0, 16'h0005, 1); #1 chk("order_idle", bus.resp_valid, 0);
        cycle(0, 0, 0, 0, 16'h0006, 0); #1;
        chk("next_head_ptr", bus.resp_ptr, 1);
        chk("next_head_id", bus.resp_id, 5);
        cycle(0, 0, 0, 0, 16'h0006, 1);
        // round-robin, back-to-back
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, i + 1, 0, 0, '0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, i, '0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 16'h0007, 1); #1;
            chk("rr_b2b_ptr", bus.resp_ptr, i);
            chk("rr_b2b_valid", bus.resp_valid, 1);
        end
        cycle(0, 0, 0, 0, 16'h0007, 1); #1 chk("rr_drain", bus.resp_valid, 0);
        for (int i = 0; i < 3; i++) cycle(1, 4 + i, 0, 0, '0, 0);
        cycle(0, 0, 1, 0, '0, 0);
        cycle(0, 0, 0, 0, 16'h0001, 0);
        cycle(0, 0, 0, 0, 16'h0001, 1);
        cycle(1, 7, 0, 0, '0, 0);
        cycle(0, 0, 1, 0, '0, 0);
        cycle(0, 0, 1, 2, '0, 0);
        cycle(0, 0, 0, 0, 16'h0005, 0); #1 chk("rr_base1_first", bus.resp_ptr, 2);
        cycle(0, 0, 0, 0, 16'h0005, 1); #1 chk("rr_wrap", bus.resp_ptr, 0);
        cycle(0, 0, 0, 0, 16'h0005, 1);
        // full and free, then back-pressure
        do_reset();
        for (int i = 0; i < D; i++) cycle(1, i, 0, 0, '0, 0);
        #1;
        chk("full_ready", bus.alloc_ready, 0);
        chk("full_cnt", bus.ost_cnt, 16);
        cycle(0, 0, 1, 7, '0, 0);
        cycle(0, 0, 0, 0, 16'h0080, 0);
        cycle(1, 9, 0, 0, 16'h0080, 1); #1;
        chk("free_ready", bus.alloc_ready, 1);
        chk("free_ptr", bus.alloc_ptr, 7);
        chk("free_cnt", bus.ost_cnt, 15);
        cycle(1, 9, 0, 0, '0, 0); #1 chk("refill_cnt", bus.ost_cnt, 16);
        cycle(0, 0, 1, 3, '0, 0);
        cycle(0, 0, 0, 0, 16'h0008, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0, 16'h0008, 0); #1;
            chk("bp_valid", bus.resp_valid, 1);
            chk("bp_ptr", bus.resp_ptr, 3);
            chk("bp_id", bus.resp_id, 3);
            chk("bp_cnt", bus.ost_cnt, 16);
        end
        // error flag and reset while busy
        do_reset();
        cycle(1, 1, 0, 0, '0, 0);
        cycle(0, 0, 1, 9, '0, 0); #1 chk("err_set", bus.err_done, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, '0, 0); #1 chk("err_hold", bus.err_done, 1);
        end
        cycle(0, 0, 1, 0, '0, 0);
        cycle(0, 0, 0, 0, 16'h0001, 0); #1 chk("busy_before_rst", bus.resp_valid, 1);
        do_reset();
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int cands[$];
            int dptr;
            logic [D-1:0] ob;
            if (n == 1500) do_reset();
            cands = {};
            for (int k = 0; k < D; k++) if (m_vld[k] && !m_done[k]) cands.push_back(k);
            dptr = (cands.size() > 0 && $urandom_range(0, 7) != 0) ?
                   cands[$urandom_range(0, cands.size() - 1)] : int'($urandom_range(0, D - 1));
            ob = m_heads() | (($urandom_range(0, 3) == 0) ? D'($urandom) : '0);
            cycle($urandom_range(0, 1), $urandom_range(0, (1 << IW) - 1),
                  $urandom_range(0, 1), dptr, ob, $urandom_range(0, 3) != 0);
        end
        #1 check_outputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
